// File: rtl/xevious_input_pkg.sv
// Shared types and sizing helpers for the Xevious input conditioning stage.
package xevious_input_pkg;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;

  localparam int NUM_DEBOUNCED  = 7;
  localparam int COIN_CHANNELS  = 2;
  localparam int COIN_PENDING_W = 2;

  // Bits needed to hold the values 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/input_debounce.sv
// Single-bit tick-based debouncer: the state flips only after the raw input
// has disagreed with it for DEBOUNCE_MS consecutive ticks.
module input_debounce
  import xevious_input_pkg::*;
#(
  parameter int DEBOUNCE_MS = 4
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic state
);

  localparam int CNT_W = cnt_w(DEBOUNCE_MS);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= 1'b0;
      cnt   <= '0;
    end else if (tick) begin
      if (raw != state) begin
        if (cnt == CNT_W'(DEBOUNCE_MS - 1)) begin
          state <= ~state;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/xevious_input_cond.sv
// Input conditioning for the Xevious core: debounce, queued coin pulses and
// optional autofire, all timed by a pausable millisecond tick.
module xevious_input_cond
  import xevious_input_pkg::*;
#(
  parameter int TICK_DIV         = 18000,
  parameter int DEBOUNCE_MS      = 4,
  parameter int COIN_PULSE_MS    = 100,
  parameter int COIN_GAP_MS      = 100,
  parameter int COIN_QUEUE       = 3,
  parameter int AUTOFIRE_HALF_MS = 33
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       pause,
  input  logic       autofire_en,
  input  logic [1:0] coin_in,
  input  logic [1:0] start_in,
  input  logic       service_in,
  input  logic [1:0] fire_in,
  output logic [1:0] coin_out,
  output logic [1:0] start_out,
  output logic       service_out,
  output logic [1:0] fire_out,
  output logic [3:0] coin_pending
);

  localparam int PRESC_W = cnt_w(TICK_DIV - 1);
  localparam int TMAX    = (COIN_PULSE_MS > COIN_GAP_MS) ? COIN_PULSE_MS : COIN_GAP_MS;
  localparam int TIMER_W = cnt_w(TMAX);
  localparam int QUEUE_W = cnt_w(COIN_QUEUE);
  localparam int PHASE_W = cnt_w(AUTOFIRE_HALF_MS);

  logic [PRESC_W-1:0]       presc;
  logic                     tick;
  logic [NUM_DEBOUNCED-1:0] raw_vec;
  logic [NUM_DEBOUNCED-1:0] deb_vec;

  assign tick = !pause && (presc == PRESC_W'(TICK_DIV - 1));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      presc <= '0;
    end else if (!pause) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  // Bit map: [1:0] coin, [3:2] start, [4] service, [6:5] fire.
  assign raw_vec = {fire_in, service_in, start_in, coin_in};

  for (genvar i = 0; i < NUM_DEBOUNCED; i++) begin : g_deb
    input_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_deb (
      .clk_sys (clk_sys),
      .reset   (reset),
      .tick    (tick),
      .raw     (raw_vec[i]),
      .state   (deb_vec[i])
    );
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      start_out   <= '0;
      service_out <= 1'b0;
    end else begin
      start_out   <= deb_vec[3:2];
      service_out <= deb_vec[4];
    end
  end

  for (genvar c = 0; c < COIN_CHANNELS; c++) begin : g_coin
    coin_state_t        state, state_n;
    logic [TIMER_W-1:0] timer, timer_n;
    logic [QUEUE_W-1:0] pending, pending_n;
    logic               coin_prev;
    logic               coin_q;
    logic               coin_rise;
    logic               dequeue;
    logic               accept;

    assign coin_rise = deb_vec[c] & ~coin_prev;

    // A new pulse is not launched while paused so every output holds.
    always_comb begin
      state_n = state;
      timer_n = timer;
      dequeue = 1'b0;
      case (state)
        IDLE: begin
          if (pending != '0 && !pause) begin
            state_n = PULSE;
            timer_n = TIMER_W'(COIN_PULSE_MS);
            dequeue = 1'b1;
          end
        end
        PULSE: begin
          if (timer == '0) begin
            state_n = GAP;
            timer_n = TIMER_W'(COIN_GAP_MS);
          end else if (tick) begin
            timer_n = timer - 1'b1;
          end
        end
        GAP: begin
          if (timer == '0) begin
            state_n = IDLE;
          end else if (tick) begin
            timer_n = timer - 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    always_comb begin
      accept    = coin_rise && ((pending != QUEUE_W'(COIN_QUEUE)) || dequeue);
      pending_n = pending;
      case ({accept, dequeue})
        2'b10:   pending_n = pending + 1'b1;
        2'b01:   pending_n = pending - 1'b1;
        default: pending_n = pending;
      endcase
    end

    always_ff @(posedge clk_sys) begin
      if (reset) begin
        state     <= IDLE;
        timer     <= '0;
        pending   <= '0;
        coin_prev <= 1'b0;
        coin_q    <= 1'b0;
      end else begin
        state     <= state_n;
        timer     <= timer_n;
        pending   <= pending_n;
        coin_prev <= deb_vec[c];
        coin_q    <= (state_n == PULSE);
      end
    end

    assign coin_out[c] = coin_q;
    assign coin_pending[COIN_PENDING_W*c +: COIN_PENDING_W] = COIN_PENDING_W'(pending);
  end

  for (genvar f = 0; f < 2; f++) begin : g_fire
    logic               fire_deb;
    logic               fire_prev;
    logic               en_prev;
    logic               fire_q;
    logic [PHASE_W-1:0] phase;

    assign fire_deb = deb_vec[5 + f];

    // A fresh press, or autofire being switched on mid-hold, restarts the phase high.
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        fire_prev <= 1'b0;
        en_prev   <= 1'b0;
        fire_q    <= 1'b0;
        phase     <= '0;
      end else begin
        fire_prev <= fire_deb;
        en_prev   <= autofire_en;
        if (!autofire_en) begin
          fire_q <= fire_deb;
          phase  <= '0;
        end else if (!fire_deb) begin
          fire_q <= 1'b0;
          phase  <= '0;
        end else if (!fire_prev || !en_prev) begin
          fire_q <= 1'b1;
          phase  <= '0;
        end else if (tick) begin
          if (phase == PHASE_W'(AUTOFIRE_HALF_MS - 1)) begin
            fire_q <= ~fire_q;
            phase  <= '0;
          end else begin
            phase <= phase + 1'b1;
          end
        end
      end
    end

    assign fire_out[f] = fire_q;
  end

endmodule

// File: tb/tb_xevious_input_cond.sv
// Directed bench for xevious_input_cond with a 4-cycle tick; a second instance
// with a long coin pulse lets several presses land inside one pulse.
module tb_xevious_input_cond;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       pause = 1'b0;
  logic       autofire_en = 1'b0;
  logic [1:0] coin_in = '0;
  logic [1:0] start_in = '0;
  logic       service_in = 1'b0;
  logic [1:0] fire_in = '0;

  logic [1:0] coin_out, start_out, fire_out;
  logic       service_out;
  logic [3:0] coin_pending;
  logic [1:0] q_coin_out, q_start_out, q_fire_out;
  logic       q_service_out;
  logic [3:0] q_coin_pending;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ph = 0;
  int main_rises[$];
  int main_falls[$];
  int q_rises[$];
  logic main_prev = 1'b0;
  logic q_prev = 1'b0;

  xevious_input_cond #(
    .TICK_DIV(4), .DEBOUNCE_MS(4), .COIN_PULSE_MS(5), .COIN_GAP_MS(3),
    .COIN_QUEUE(3), .AUTOFIRE_HALF_MS(2)
  ) u_dut (
    .clk_sys(clk_sys), .reset(reset), .pause(pause), .autofire_en(autofire_en),
    .coin_in(coin_in), .start_in(start_in), .service_in(service_in), .fire_in(fire_in),
    .coin_out(coin_out), .start_out(start_out), .service_out(service_out),
    .fire_out(fire_out), .coin_pending(coin_pending)
  );

  xevious_input_cond #(
    .TICK_DIV(4), .DEBOUNCE_MS(4), .COIN_PULSE_MS(40), .COIN_GAP_MS(8),
    .COIN_QUEUE(3), .AUTOFIRE_HALF_MS(2)
  ) u_dut_q (
    .clk_sys(clk_sys), .reset(reset), .pause(pause), .autofire_en(autofire_en),
    .coin_in(coin_in), .start_in(start_in), .service_in(service_in), .fire_in(fire_in),
    .coin_out(q_coin_out), .start_out(q_start_out), .service_out(q_service_out),
    .fire_out(q_fire_out), .coin_pending(q_coin_pending)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Expected tick phase: ph returns to 0 on the edge that carries a tick.
  always @(posedge clk_sys) begin
    if (reset) ph <= 0;
    else if (!pause) ph <= (ph == 3) ? 0 : ph + 1;
  end

  always @(negedge clk_sys) begin
    if (coin_out[0] && !main_prev) main_rises.push_back(cyc);
    if (!coin_out[0] && main_prev) main_falls.push_back(cyc);
    if (q_coin_out[0] && !q_prev) q_rises.push_back(cyc);
    main_prev <= coin_out[0];
    q_prev    <= q_coin_out[0];
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic align_tick();
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (ph != 0 && n < 8);
  endtask

  task automatic clear_queues();
    main_rises.delete();
    main_falls.delete();
    q_rises.delete();
  endtask

  task automatic coin_press();
    align_tick();
    coin_in[0] = 1'b1;
    step(16);
    coin_in[0] = 1'b0;
    step(15);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(3);
    checks++; if (coin_out !== 2'b00) begin errors++; $display("[TB] FAIL reset_coin: got %b expected 00", coin_out); end
    checks++; if (start_out !== 2'b00) begin errors++; $display("[TB] FAIL reset_start: got %b expected 00", start_out); end
    checks++; if (service_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_service: got %b expected 0", service_out); end
    checks++; if (fire_out !== 2'b00) begin errors++; $display("[TB] FAIL reset_fire: got %b expected 00", fire_out); end
    checks++; if (coin_pending !== 4'h0) begin errors++; $display("[TB] FAIL reset_pending: got %h expected 0", coin_pending); end
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_start_service();
    int ones;
    ones = 0;
    align_tick();
    start_in[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (start_out[0] !== 1'b0) ones++;
    end
    start_in[0] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (start_out[0] !== 1'b0) ones++;
    end
    checks++; if (ones != 0) begin errors++; $display("[TB] FAIL start_glitch: got %0d high samples expected 0", ones); end

    align_tick();
    start_in[0] = 1'b1;
    service_in  = 1'b1;
    step(16);
    checks++; if (start_out[0] !== 1'b0) begin errors++; $display("[TB] FAIL start_early: got %b expected 0", start_out[0]); end
    checks++; if (service_out !== 1'b0) begin errors++; $display("[TB] FAIL service_early: got %b expected 0", service_out); end
    step(1);
    checks++; if (start_out !== 2'b01) begin errors++; $display("[TB] FAIL start_rise: got %b expected 01", start_out); end
    checks++; if (service_out !== 1'b1) begin errors++; $display("[TB] FAIL service_rise: got %b expected 1", service_out); end
    start_in[0] = 1'b0;
    service_in  = 1'b0;
    step(40);
    checks++; if (start_out !== 2'b00) begin errors++; $display("[TB] FAIL start_release: got %b expected 00", start_out); end
    checks++; if (service_out !== 1'b0) begin errors++; $display("[TB] FAIL service_release: got %b expected 0", service_out); end
  endtask

  task automatic test_fire_direct();
    autofire_en = 1'b0;
    align_tick();
    fire_in[0] = 1'b1;
    step(16);
    checks++; if (fire_out[0] !== 1'b0) begin errors++; $display("[TB] FAIL fire_direct_early: got %b expected 0", fire_out[0]); end
    step(1);
    checks++; if (fire_out !== 2'b01) begin errors++; $display("[TB] FAIL fire_direct_rise: got %b expected 01", fire_out); end
    fire_in[0] = 1'b0;
    step(24);
    checks++; if (fire_out !== 2'b00) begin errors++; $display("[TB] FAIL fire_direct_release: got %b expected 00", fire_out); end
  endtask

  task automatic test_single_coin();
    int n;
    clear_queues();
    align_tick();
    coin_in[0] = 1'b1;
    step(17);
    checks++; if (coin_out[0] !== 1'b0) begin errors++; $display("[TB] FAIL coin_early: got %b expected 0", coin_out[0]); end
    checks++; if (coin_pending !== 4'h1) begin errors++; $display("[TB] FAIL coin_enqueue: got %h expected 1", coin_pending); end
    step(1);
    checks++; if (coin_out !== 2'b01) begin errors++; $display("[TB] FAIL coin_rise: got %b expected 01", coin_out); end
    checks++; if (coin_pending !== 4'h0) begin errors++; $display("[TB] FAIL coin_dequeue: got %h expected 0", coin_pending); end
    step(22);
    coin_in[0] = 1'b0;
    n = 0;
    while (main_falls.size() == 0 && n < 100) begin
      step(1);
      n++;
    end
    checks++;
    if (main_falls.size() == 0 || main_rises.size() == 0) begin
      errors++; $display("[TB] FAIL coin_fall_timeout: got no fall within 100 cycles expected a fall");
    end else if ((main_falls[0] - main_rises[0]) < 19 || (main_falls[0] - main_rises[0]) > 21) begin
      errors++; $display("[TB] FAIL coin_length: got %0d cycles expected 20 +/- 1", main_falls[0] - main_rises[0]);
    end
    step(20);
    checks++; if (coin_pending !== 4'h0) begin errors++; $display("[TB] FAIL coin_pending_end: got %h expected 0", coin_pending); end
    checks++; if (main_rises.size() != 1) begin errors++; $display("[TB] FAIL coin_count: got %0d pulses expected 1", main_rises.size()); end
  endtask

  task automatic test_queue_saturation();
    step(80);
    clear_queues();
    for (int k = 0; k < 5; k++) coin_press();
    checks++; if (q_coin_pending !== 4'h3) begin errors++; $display("[TB] FAIL queue_cap: got %h expected 3", q_coin_pending); end
    step(1200);
    checks++; if (q_rises.size() != 4) begin errors++; $display("[TB] FAIL queue_pulses: got %0d expected 4", q_rises.size()); end
    for (int i = 1; i < q_rises.size(); i++) begin
      checks++;
      if ((q_rises[i] - q_rises[i-1]) < 192 || (q_rises[i] - q_rises[i-1]) > 193) begin
        errors++; $display("[TB] FAIL queue_spacing: got %0d cycles expected 192 (+1)", q_rises[i] - q_rises[i-1]);
      end
    end
    checks++; if (main_rises.size() != 5) begin errors++; $display("[TB] FAIL b2b_pulses: got %0d expected 5", main_rises.size()); end
    for (int i = 1; i < main_rises.size(); i++) begin
      checks++;
      if ((main_rises[i] - main_rises[i-1]) < 32 || (main_rises[i] - main_rises[i-1]) > 33) begin
        errors++; $display("[TB] FAIL b2b_spacing: got %0d cycles expected 32 (+1)", main_rises[i] - main_rises[i-1]);
      end
    end
    checks++; if (q_coin_pending !== 4'h0) begin errors++; $display("[TB] FAIL queue_drained: got %h expected 0", q_coin_pending); end
  endtask

  task automatic test_reset_mid_gap();
    int n;
    clear_queues();
    for (int k = 0; k < 3; k++) coin_press();
    n = 0;
    while (q_coin_out[0] !== 1'b0 && n < 200) begin
      step(1);
      n++;
    end
    step(4);
    checks++; if (q_coin_pending !== 4'h2) begin errors++; $display("[TB] FAIL gap_pending: got %h expected 2", q_coin_pending); end
    checks++; if (q_coin_out !== 2'b00) begin errors++; $display("[TB] FAIL gap_coin: got %b expected 00", q_coin_out); end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checks++; if (q_coin_pending !== 4'h0) begin errors++; $display("[TB] FAIL rst_gap_pending: got %h expected 0", q_coin_pending); end
    checks++; if (q_coin_out !== 2'b00) begin errors++; $display("[TB] FAIL rst_gap_coin: got %b expected 00", q_coin_out); end
    checks++; if ({coin_out, start_out, service_out, fire_out, coin_pending} !== 11'b0) begin
      errors++; $display("[TB] FAIL rst_gap_outputs: got %b expected 0", {coin_out, start_out, service_out, fire_out, coin_pending});
    end
    clear_queues();
    step(300);
    checks++; if (q_rises.size() + main_rises.size() != 0) begin
      errors++; $display("[TB] FAIL rst_gap_no_pulse: got %0d pulses expected 0", q_rises.size() + main_rises.size());
    end
  endtask

  task automatic test_pause();
    int lows;
    int n;
    lows = 0;
    clear_queues();
    align_tick();
    coin_in[0] = 1'b1;
    step(16);
    coin_in[0] = 1'b0;
    step(2);
    checks++; if (coin_out[0] !== 1'b1) begin errors++; $display("[TB] FAIL pause_pre: got %b expected 1", coin_out[0]); end
    step(8);
    pause = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (coin_out[0] !== 1'b1) lows++;
    end
    pause = 1'b0;
    checks++; if (lows != 0) begin errors++; $display("[TB] FAIL pause_hold: got %0d low samples expected 0", lows); end
    n = 0;
    while (main_falls.size() == 0 && n < 300) begin
      step(1);
      n++;
    end
    checks++;
    if (main_falls.size() == 0 || main_rises.size() == 0) begin
      errors++; $display("[TB] FAIL pause_timeout: got no fall within 300 cycles expected a fall");
    end else if ((main_falls[0] - main_rises[0]) < 119 || (main_falls[0] - main_rises[0]) > 121) begin
      errors++; $display("[TB] FAIL pause_length: got %0d cycles expected 120 +/- 1", main_falls[0] - main_rises[0]);
    end
    step(40);
  endtask

  task automatic test_autofire();
    logic expv;
    autofire_en = 1'b1;
    step(2);
    align_tick();
    fire_in[1] = 1'b1;
    for (int off = 1; off <= 177; off++) begin
      step(1);
      if (off == 160) fire_in[1] = 1'b0;
      if (off < 17) expv = 1'b0;
      else if (off == 177) expv = 1'b0;
      else expv = (((off - 16) / 8) % 2 == 0) ? 1'b1 : 1'b0;
      if ((off >= 14 && off <= 64) || off >= 170) begin
        checks++;
        if (fire_out !== {expv, 1'b0}) begin
          errors++; $display("[TB] FAIL autofire_off%0d: got %b expected %b", off, fire_out, {expv, 1'b0});
        end
      end
    end
    autofire_en = 1'b0;
    step(10);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting xevious_input_cond bench");
    test_reset();
    test_start_service();
    test_fire_direct();
    test_single_coin();
    test_queue_saturation();
    test_reset_mid_gap();
    test_pause();
    test_autofire();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
